// File: rtl/div_i12_o12_seq_if.sv
// Request/response handshake bundle for the sequential 12/6 restoring divider.
// The master issues operands and accepts results; the slave is the divider.
interface div_i12_o12_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] dividend;
    logic [5:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] quotient;
    logic [5:0]  remainder;
    logic        div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_i12_o12_seq.sv
// Sequential restoring divider: 12-bit dividend / 6-bit divisor, one quotient bit per cycle.
// Optional zeroing of quotient LSBs mirrors the approximate multiplier family.
module div_i12_o12_seq #(
    parameter int unsigned APPROX_LSB = 0
) (
    input logic              clk,
    input logic              rst_n,
    div_i12_o12_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [11:0] QMASK = 12'hFFF << APPROX_LSB;

    state_t      state, state_nx;
    logic [6:0]  prem, prem_nx;
    logic [11:0] q_sr, q_sr_nx;
    logic [5:0]  dsr, dsr_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [11:0] quo, quo_nx;
    logic [5:0]  rem, rem_nx;
    logic        dbz, dbz_nx;
    logic [6:0]  shifted;
    logic [7:0]  trial;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            prem  <= '0;
            q_sr  <= '0;
            dsr   <= '0;
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
            dbz   <= 1'b0;
        end else begin
            state <= state_nx;
            prem  <= prem_nx;
            q_sr  <= q_sr_nx;
            dsr   <= dsr_nx;
            cnt   <= cnt_nx;
            quo   <= quo_nx;
            rem   <= rem_nx;
            dbz   <= dbz_nx;
        end
    end

    always_comb begin
        state_nx = state;
        prem_nx  = prem;
        q_sr_nx  = q_sr;
        dsr_nx   = dsr;
        cnt_nx   = cnt;
        quo_nx   = quo;
        rem_nx   = rem;
        dbz_nx   = dbz;
        shifted  = {prem[5:0], q_sr[11]};
        // Extra MSB on the subtraction acts as the borrow/sign of the trial.
        trial    = {1'b0, shifted} - {2'b00, dsr};

        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    dsr_nx = bus.divisor;
                    if (bus.divisor == '0) begin
                        state_nx = DONE;
                        q_sr_nx  = 12'hFFF;
                        prem_nx  = {1'b0, bus.dividend[5:0]};
                        cnt_nx   = '0;
                        quo_nx   = 12'hFFF & QMASK;
                        rem_nx   = bus.dividend[5:0];
                        dbz_nx   = 1'b1;
                    end else begin
                        state_nx = CALC;
                        q_sr_nx  = bus.dividend;
                        prem_nx  = '0;
                        cnt_nx   = 4'd11;
                    end
                end
            end
            CALC: begin
                if (!trial[7]) begin
                    prem_nx = trial[6:0];
                    q_sr_nx = {q_sr[10:0], 1'b1};
                end else begin
                    prem_nx = shifted;
                    q_sr_nx = {q_sr[10:0], 1'b0};
                end
                if (cnt == '0) begin
                    // Result registers load only on completion so the previous
                    // result stays visible while a new division is in progress.
                    state_nx = DONE;
                    cnt_nx   = '0;
                    quo_nx   = q_sr_nx & QMASK;
                    rem_nx   = prem_nx[5:0];
                    dbz_nx   = 1'b0;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.quotient    = quo;
    assign bus.remainder   = rem;
    assign bus.div_by_zero = dbz;
endmodule
